controlador_oposto: RTL and testbench

// Sequencer wrapped around the combinational negation stage modulo_oposto. On start, walks NUM_ELEM
// 8-bit unsigned operands in a source buffer and feeds each one through modulo_oposto. It saturates
// the 9-bit signed result to 8-bit signed and writes it to a result buffer under ready backpressure.

---
 rtl/coproc_pkg.sv | 36 +++
 rtl/modulo_oposto.sv | 12 +
 rtl/controlador_oposto.sv | 118 +++++++++++
 tb/tb_controlador_oposto.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/coproc_pkg.sv
// Shared types and constants for the coprocessor "opposite" datapath:
// operand/result widths, sequencer states and the 8-bit saturation helper.
package coproc_pkg;

    localparam int DATA_W = 8;
    localparam int RES_W  = 9;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        WRITE,
        DONE
    } state_t;

    localparam logic signed [DATA_W-1:0] SAT_MAX = 8'sh7F;
    localparam logic signed [DATA_W-1:0] SAT_MIN = 8'sh80;

    typedef struct packed {
        logic [DATA_W-1:0] val;
        logic              clip;
    } sat_t;

    function automatic sat_t sat8(input logic signed [RES_W-1:0] n);
        sat_t r;
        if (n < -9'sd128) begin
            r = '{val: SAT_MIN, clip: 1'b1};
        end else if (n > 9'sd127) begin
            r = '{val: SAT_MAX, clip: 1'b1};
        end else begin
            r = '{val: n[DATA_W-1:0], clip: 1'b0};
        end
        return r;
    endfunction

endpackage

// File: rtl/modulo_oposto.sv
// Combinational negation stage: widens the unsigned operand by one bit
// and returns its two's complement opposite (-255..0).
module modulo_oposto
    import coproc_pkg::*;
(
    input  logic [DATA_W-1:0] entrada,
    output logic [RES_W-1:0]  saida
);

    assign saida = -{1'b0, entrada};

endmodule

// File: rtl/controlador_oposto.sv
// Sequencer that streams NUM_ELEM operands through modulo_oposto,
// saturates to signed 8 bits and writes results under ready backpressure.
module controlador_oposto
    import coproc_pkg::*;
#(
    parameter int NUM_ELEM = 25,
    parameter int ADDR_W   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic              wr_ready
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_ELEM - 1);

    state_t              state_q;
    logic [ADDR_W-1:0]   idx_q;
    logic                busy_q;
    logic                done_q;
    logic                overflow_q;
    logic                rd_en_q;
    logic [ADDR_W-1:0]   rd_addr_q;
    logic                wr_en_q;
    logic [ADDR_W-1:0]   wr_addr_q;
    logic [DATA_W-1:0]   wr_data_q;

    logic [RES_W-1:0]    neg;
    sat_t                sat_d;

    modulo_oposto u_neg (
        .entrada (rd_data),
        .saida   (neg)
    );

    assign sat_d = sat8(signed'(neg));

    // Strobes are set on entry to READ/WRITE so they are high in that state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q    <= READ;
                        idx_q      <= '0;
                        overflow_q <= 1'b0;
                        busy_q     <= 1'b1;
                        rd_en_q    <= 1'b1;
                        rd_addr_q  <= '0;
                    end
                end
                READ: begin
                    rd_en_q <= 1'b0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    wr_data_q <= sat_d.val;
                    if (sat_d.clip) begin
                        overflow_q <= 1'b1;
                    end
                    wr_en_q   <= 1'b1;
                    wr_addr_q <= idx_q;
                    state_q   <= WRITE;
                end
                WRITE: begin
                    if (wr_ready) begin
                        wr_en_q <= 1'b0;
                        if (idx_q == LAST) begin
                            state_q <= DONE;
                        end else begin
                            idx_q     <= idx_q + 1'b1;
                            rd_en_q   <= 1'b1;
                            rd_addr_q <= idx_q + 1'b1;
                            state_q   <= READ;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign overflow = overflow_q;
    assign rd_en    = rd_en_q;
    assign rd_addr  = rd_addr_q;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;

endmodule

// File: tb/tb_controlador_oposto.sv
// Bench for controlador_oposto: directed and random operations checked
// against an arithmetic model of negate-and-saturate.
module tb_controlador_oposto;

    localparam int N  = 4;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          busy;
    logic          done;
    logic          overflow;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          wr_ready;

    int checks   = 0;
    int failures = 0;

    logic [7:0]    src [32];
    logic [AW-1:0] wa_q [$];
    logic [7:0]    wd_q [$];
    logic [AW-1:0] ra_q [$];
    int            done_cnt  = 0;
    int            stall_cnt = 0;

    controlador_oposto #(
        .NUM_ELEM (N),
        .ADDR_W   (AW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .overflow (overflow),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_ready (wr_ready)
    );

    always #5 clk = ~clk;

    // Source memory: one-cycle read latency.
    always @(posedge clk) begin
        if (rd_en) rd_data <= src[rd_addr];
    end

    always @(posedge clk) begin
        if (wr_en && wr_ready) begin
            wa_q.push_back(wr_addr);
            wd_q.push_back(wr_data);
        end
        if (wr_en && !wr_ready) stall_cnt <= stall_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
        if (rd_en) ra_q.push_back(rd_addr);
    end

    function automatic logic [7:0] ref_val(input logic [7:0] d);
        int n;
        n = -int'(d);
        if (n < -128) return 8'h80;
        if (n > 127) return 8'h7F;
        return n[7:0];
    endfunction

    function automatic logic ref_ovf();
        logic o;
        o = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (int'(src[i]) > 128) o = 1'b1;
        end
        return o;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Modes: 0 ready, 1 stall element 1 for 5 cycles, 2 random ready,
    // 3 start pulsed while busy and in the DONE cycle.
    task automatic run_op(input int mode, output int cyc);
        int stall_left;
        bit bp_done;
        stall_left = 0;
        bp_done    = 0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("ovf_clr", 32'(overflow), 0);
        chk("busy_on", 32'(busy), 1);
        cyc = 0;
        while (cyc < 300 && !done) begin
            if (mode == 1) begin
                if (!bp_done && wr_en && wr_addr == 1) begin
                    bp_done    = 1;
                    stall_left = 5;
                end
                if (stall_left > 0) begin
                    chk("bp_wr_en", 32'(wr_en), 1);
                    chk("bp_addr", 32'(wr_addr), 1);
                    chk("bp_data", 32'(wr_data), 32'(ref_val(src[1])));
                    wr_ready = 1'b0;
                    stall_left--;
                end else begin
                    wr_ready = 1'b1;
                end
            end else if (mode == 2) begin
                wr_ready = 1'($urandom_range(0, 1));
            end else if (mode == 3) begin
                start = (cyc == 5 || cyc == 12);
            end
            @(posedge clk);
            cyc++;
            #1;
        end
        chk("op_done", 32'(done), 1);
        wr_ready = 1'b1;
        start    = 1'b0;
    endtask

    task automatic do_run(input int mode, input string tag);
        int base, rbase, d0, s0, cyc, exp_cyc;
        base  = wa_q.size();
        rbase = ra_q.size();
        d0    = done_cnt;
        s0    = stall_cnt;
        @(negedge clk);
        run_op(mode, cyc);
        exp_cyc = 3 * N + 1;
        if (mode == 1) exp_cyc += 5;
        if (mode == 2) exp_cyc += stall_cnt - s0;
        chk({tag, "_lat"}, 32'(cyc), 32'(exp_cyc));
        chk({tag, "_ovf"}, 32'(overflow), 32'(ref_ovf()));
        chk({tag, "_nwr"}, 32'(wa_q.size() - base), N);
        for (int i = 0; i < N; i++) begin
            if (base + i < wa_q.size()) begin
                chk({tag, "_waddr"}, 32'(wa_q[base+i]), 32'(i));
                chk({tag, "_wdata"}, 32'(wd_q[base+i]),
                    32'(ref_val(src[i])));
            end
        end
        chk({tag, "_nrd"}, 32'(ra_q.size() - rbase), N);
        if (ra_q.size() > rbase) begin
            chk({tag, "_rd0"}, 32'(ra_q[rbase]), 0);
        end
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_pulses"}, 32'(done_cnt - d0), 1);
        chk({tag, "_idle"}, 32'(busy), 0);
    endtask

    initial begin
        int base, cyc;
        rst_n    = 1'b1;
        start    = 1'b0;
        wr_ready = 1'b1;
        for (int i = 0; i < 32; i++) src[i] = 8'h00;

        #3 rst_n = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_rd_en", 32'(rd_en), 0);
        chk("rst_wr_en", 32'(wr_en), 0);
        chk("rst_rd_addr", 32'(rd_addr), 0);
        chk("rst_wr_addr", 32'(wr_addr), 0);
        chk("rst_wr_data", 32'(wr_data), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("idle_busy", 32'(busy), 0);
        chk("idle_reads", 32'(ra_q.size()), 0);

        src[0] = 8'd0; src[1] = 8'd1; src[2] = 8'd127; src[3] = 8'd128;
        do_run(0, "basic");

        src[0] = 8'd129; src[1] = 8'd255; src[2] = 8'd2; src[3] = 8'd0;
        do_run(0, "sat");

        src[0] = 8'd10; src[1] = 8'd200; src[2] = 8'd77; src[3] = 8'd128;
        do_run(1, "bp");

        src[0] = 8'd5; src[1] = 8'd6; src[2] = 8'd7; src[3] = 8'd8;
        do_run(3, "spam");

        // Abort with reset while element 2 waits on wr_ready.
        for (int i = 0; i < N; i++) src[i] = 8'($urandom_range(0, 255));
        base = wa_q.size();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 0;
        while (cyc < 100 && !(wr_en && wr_addr == 2)) begin
            @(posedge clk);
            cyc++;
            #1;
        end
        wr_ready = 1'b0;
        chk("mw_reach", 32'(wr_en && wr_addr == 2), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mw_wr_en", 32'(wr_en), 0);
        chk("mw_busy", 32'(busy), 0);
        chk("mw_wr_addr", 32'(wr_addr), 0);
        repeat (2) @(posedge clk);
        #1;
        chk("mw_nwr", 32'(wa_q.size() - base), 2);
        @(negedge clk);
        rst_n    = 1'b1;
        wr_ready = 1'b1;
        do_run(0, "post_rst");

        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < N; i++) begin
                src[i] = 8'($urandom_range(0, 255));
            end
            do_run(2, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
